// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule engine: S-box, GF(2^8) helpers,
// key-size-derived constants and the engine state encoding.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_GEN,
        KS_FIN
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Packages cannot be parameterised, so the per-key-size constants are
    // computed from KEY_BITS by the instantiating module through these.
    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return nk_of(key_bits) + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_sub_word.sv
// Combinational AES SubWord: independent S-box substitution of each byte.
module key_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES key schedule: one 32-bit word per cycle from an NK-word
// sliding window, packed into 128-bit round keys on a valid/ready stream.
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                done
);

    localparam int NK  = nk_of(KEY_BITS);
    localparam int NW  = nw_of(KEY_BITS);
    localparam int IW  = 6;
    localparam int PW  = 3;
    localparam int NKW = $clog2(NK);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("key_schedule_seq: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_t      state;
    logic [IW-1:0]  i;
    logic [PW-1:0]  phase;      // i % NK, kept as its own counter to avoid a divider
    logic [7:0]     rcon;
    logic [31:0]    win [NK];   // win[0] = w[i-NK] (oldest), win[NK-1] = w[i-1]
    logic [95:0]    asm_buf;    // first three words of the round key being assembled

    logic           stall;
    logic           produce;
    logic           key_phase;
    logic           sub_alt;
    logic [31:0]    newest;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    temp;
    logic [31:0]    w_new;

    assign stall     = rk_valid && !rk_ready;
    assign produce   = (state == KS_GEN) && (i < IW'(NW)) && !stall;
    assign key_phase = i < IW'(NK);
    assign sub_alt   = (NK == 8) && (phase == 3'd4);
    assign newest    = win[NK-1];
    assign sub_in    = sub_alt ? newest : {newest[23:0], newest[31:24]};

    key_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        temp = newest;
        if (phase == '0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (sub_alt)
            temp = sub_out;
        w_new = key_phase ? win[i[NKW-1:0]] : (win[0] ^ temp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= KS_IDLE;
            i        <= '0;
            phase    <= '0;
            rcon     <= RCON_INIT;
            // NOTE: the window is a handful of flops, not a RAM, so clearing it on reset costs nothing and keeps key material from lingering.
            for (int k = 0; k < NK; k++)
                win[k] <= '0;
            asm_buf  <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            // NOTE: with non-blocking assignments the last write in the block wins, so a round key loaded below overrides this handshake clear.
            done <= 1'b0;
            if (rk_valid && rk_ready)
                rk_valid <= 1'b0;

            case (state)
                KS_IDLE: begin
                    if (start) begin
                        state <= KS_GEN;
                        busy  <= 1'b1;
                        i     <= '0;
                        phase <= '0;
                        rcon  <= RCON_INIT;
                        for (int k = 0; k < NK; k++)
                            win[k] <= key_in[KEY_BITS-1-32*k -: 32];
                    end
                end

                KS_GEN: begin
                    if (produce) begin
                        i       <= i + 1'b1;
                        phase   <= (phase == PW'(NK - 1)) ? '0 : phase + 1'b1;
                        asm_buf <= {asm_buf[63:0], w_new};
                        // Key words are read in place; the window only slides once derived words appear.
                        if (!key_phase) begin
                            for (int k = 0; k < NK - 1; k++)
                                win[k] <= win[k+1];
                            win[NK-1] <= w_new;
                            if (phase == '0)
                                rcon <= xtime(rcon);
                        end
                        if (i[1:0] == 2'b11) begin
                            rk_data  <= {asm_buf, w_new};
                            rk_index <= i[5:2];
                            rk_valid <= 1'b1;
                        end
                    end
                    if (i == IW'(NW) && rk_valid && rk_ready) begin
                        state <= KS_FIN;
                        done  <= 1'b1;
                    end
                end

                KS_FIN: begin
                    state <= KS_IDLE;
                    busy  <= 1'b0;
                end

                default: state <= KS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Scoreboard bench for key_schedule_seq: AES-128/192/256 instances driven with
// known-answer keys; a monitor per instance checks every round-key handshake.
module tb_key_schedule_seq;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        logic [127:0] mask;
    } exp_t;

    localparam logic [127:0] FULL = {128{1'b1}};
    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KALT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] RK128 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic clk = 1'b0;
    logic rst;

    logic         start_128, busy_128, valid_128, ready_128, done_128;
    logic [127:0] key_128, data_128;
    logic [3:0]   idx_128;
    logic         start_192, busy_192, valid_192, ready_192, done_192;
    logic [191:0] key_192;
    logic [127:0] data_192;
    logic [3:0]   idx_192;
    logic         start_256, busy_256, valid_256, ready_256, done_256;
    logic [255:0] key_256;
    logic [127:0] data_256;
    logic [3:0]   idx_256;

    int n_checks = 0;
    int n_errors = 0;
    exp_t q128[$];
    exp_t q192[$];
    exp_t q256[$];

    always #5 clk = ~clk;

    key_schedule_seq #(.KEY_BITS(128)) u_dut_128 (
        .clk(clk), .rst(rst), .start(start_128), .key_in(key_128), .busy(busy_128),
        .rk_valid(valid_128), .rk_ready(ready_128), .rk_data(data_128), .rk_index(idx_128), .done(done_128));

    key_schedule_seq #(.KEY_BITS(192)) u_dut_192 (
        .clk(clk), .rst(rst), .start(start_192), .key_in(key_192), .busy(busy_192),
        .rk_valid(valid_192), .rk_ready(ready_192), .rk_data(data_192), .rk_index(idx_192), .done(done_192));

    key_schedule_seq #(.KEY_BITS(256)) u_dut_256 (
        .clk(clk), .rst(rst), .start(start_256), .key_in(key_256), .busy(busy_256),
        .rk_valid(valid_256), .rk_ready(ready_256), .rk_data(data_256), .rk_index(idx_256), .done(done_256));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic score(input string name, input logic [3:0] idx, input logic [127:0] data, input exp_t e);
        check({name, "_index"}, 128'(idx), 128'(e.idx));
        check({name, "_data"}, data & e.mask, e.data & e.mask);
    endtask

    task automatic unexpected(input string name, input logic [3:0] idx);
        n_checks++;
        n_errors++;
        $display("FAIL %s_extra_round: got round %0d, expected no pending round", name, idx);
    endtask

    // Monitors: each handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && valid_128 && ready_128) begin
            if (q128.size() == 0) unexpected("k128", idx_128);
            else score("k128", idx_128, data_128, q128.pop_front());
        end
        if (!rst && valid_192 && ready_192) begin
            if (q192.size() == 0) unexpected("k192", idx_192);
            else score("k192", idx_192, data_192, q192.pop_front());
        end
        if (!rst && valid_256 && ready_256) begin
            if (q256.size() == 0) unexpected("k256", idx_256);
            else score("k256", idx_256, data_256, q256.pop_front());
        end
    end

    // Stall monitor: a round key held back by the consumer must not move.
    bit           st_prev = 1'b0;
    logic [3:0]   st_idx;
    logic [127:0] st_data;
    always @(negedge clk) begin
        if (rst) begin
            st_prev = 1'b0;
        end else begin
            if (st_prev) begin
                check("k128_stall_valid", 128'(valid_128), 128'd1);
                check("k128_stall_index", 128'(idx_128), 128'(st_idx));
                check("k128_stall_data", data_128, st_data);
            end
            st_prev = valid_128 && !ready_128;
            st_idx  = idx_128;
            st_data = data_128;
        end
    end

    task automatic push_128();
        for (int r = 0; r <= 10; r++)
            q128.push_back('{idx: 4'(r), data: RK128[r], mask: FULL});
    endtask

    // One AES-128 run: poke adds a mid-run start with another key, bp adds backpressure.
    task automatic run_128(input bit poke, input bit bp, output int done_n);
        int hold;
        bit held;
        hold   = 0;
        held   = 1'b0;
        done_n = -1;
        push_128();
        key_128   = K128;
        ready_128 = !bp;
        start_128 = 1'b1;
        @(posedge clk); #1;
        start_128 = 1'b0;
        check("k128_busy_after_start", 128'(busy_128), 128'd1);
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (done_128) begin
                done_n = n;
                break;
            end
            if (!bp) begin
                if (n == 3) check("k128_round0_not_early", 128'(valid_128), 128'd0);
                if (n == 4) check("k128_round0_latency", 128'({valid_128, idx_128}), 128'({1'b1, 4'd0}));
                if (poke && n == 10) begin
                    start_128 = 1'b1;
                    key_128   = KALT;
                end
                if (poke && n == 11) start_128 = 1'b0;
                if (poke && n == 20) check("k128_busy_mid_run", 128'(busy_128), 128'd1);
            end else begin
                if (hold > 0) begin
                    ready_128 = 1'b0;
                    hold--;
                end else if (!held && valid_128 && idx_128 == 4'd3) begin
                    held      = 1'b1;
                    hold      = 19;
                    ready_128 = 1'b0;
                end else begin
                    ready_128 = ($urandom_range(0, 9) < 3);
                end
            end
        end
        ready_128 = 1'b1;
        check("k128_done_seen", 128'(done_n > 0), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dn;
        bit   found;
        exp_t e;

        rst = 1'b1;
        start_128 = 1'b0; start_192 = 1'b0; start_256 = 1'b0;
        ready_128 = 1'b1; ready_192 = 1'b1; ready_256 = 1'b1;
        key_128 = '0; key_192 = '0; key_256 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data_128", data_128, 128'd0);
        check("reset_ctrl_128", 128'({busy_128, valid_128, done_128, idx_128}), 128'd0);
        check("reset_ctrl_192", 128'({busy_192, valid_192, done_192, idx_192}), 128'd0);
        check("reset_ctrl_256", 128'({busy_256, valid_256, done_256, idx_256}), 128'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // AES-128, ready high, ignored mid-run start, then a start coinciding with done.
        run_128(1'b1, 1'b0, dn);
        check("k128_done_cycle", 128'(dn), 128'd45);
        start_128 = 1'b1;
        key_128   = KALT;
        @(posedge clk); #1;
        start_128 = 1'b0;
        check("k128_done_one_cycle", 128'({busy_128, done_128}), 128'd0);
        repeat (6) @(posedge clk);
        #1;
        check("k128_start_at_done_ignored", 128'({busy_128, valid_128}), 128'd0);
        check("k128_queue_drained_run1", 128'(q128.size()), 128'd0);

        // AES-128 with random backpressure and a long hold on round 3.
        run_128(1'b0, 1'b1, dn);
        check("k128_queue_drained_bp", 128'(q128.size()), 128'd0);
        @(posedge clk); #1;

        // Reset in the middle of round 5.
        push_128();
        key_128   = K128;
        start_128 = 1'b1;
        @(posedge clk); #1;
        start_128 = 1'b0;
        found = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (valid_128 && idx_128 == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        check("k128_round5_reached", 128'(found), 128'd1);
        rst = 1'b1;
        #1;
        check("k128_abort_data", data_128, 128'd0);
        check("k128_abort_ctrl", 128'({busy_128, valid_128, done_128, idx_128}), 128'd0);
        q128.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("k128_idle_after_abort", 128'({busy_128, valid_128, done_128}), 128'd0);

        // Fresh run after the abort.
        run_128(1'b0, 1'b0, dn);
        check("k128_done_cycle_after_reset", 128'(dn), 128'd45);
        check("k128_queue_drained_fresh", 128'(q128.size()), 128'd0);

        // AES-192.
        for (int r = 0; r <= 12; r++) begin
            e = '{idx: 4'(r), data: 128'd0, mask: 128'd0};
            if (r == 0)  e = '{idx: 4'd0,  data: 128'h8e73b0f7da0e6452c810f32b809079e5, mask: FULL};
            if (r == 1)  e = '{idx: 4'd1,  data: 128'h62f8ead2522c6b7bfe0c91f700000000,
                               mask: {{96{1'b1}}, 32'h0}};
            if (r == 12) e = '{idx: 4'd12, data: 128'he98ba06f448c773c8ecc720401002202, mask: FULL};
            q192.push_back(e);
        end
        key_192   = K192;
        start_192 = 1'b1;
        @(posedge clk); #1;
        start_192 = 1'b0;
        dn = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done_192) begin
                dn = n;
                break;
            end
        end
        check("k192_done_cycle", 128'(dn), 128'd53);
        check("k192_queue_drained", 128'(q192.size()), 128'd0);
        @(posedge clk); #1;
        check("k192_busy_falls", 128'(busy_192), 128'd0);

        // AES-256.
        for (int r = 0; r <= 14; r++) begin
            e = '{idx: 4'(r), data: 128'd0, mask: 128'd0};
            if (r == 0)  e = '{idx: 4'd0,  data: 128'h603deb1015ca71be2b73aef0857d7781, mask: FULL};
            if (r == 1)  e = '{idx: 4'd1,  data: 128'h1f352c073b6108d72d9810a30914dff4, mask: FULL};
            if (r == 2)  e = '{idx: 4'd2,  data: {32'h9ba35411, 96'h0}, mask: {32'hffffffff, 96'h0}};
            if (r == 14) e = '{idx: 4'd14, data: 128'hfe4890d1e6188d0b046df344706c631e, mask: FULL};
            q256.push_back(e);
        end
        key_256   = K256;
        start_256 = 1'b1;
        @(posedge clk); #1;
        start_256 = 1'b0;
        dn = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done_256) begin
                dn = n;
                break;
            end
        end
        check("k256_done_cycle", 128'(dn), 128'd61);
        check("k256_queue_drained", 128'(q256.size()), 128'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
